// File: rtl/stream_beat_tracker_pkg.sv
// Shared types/constants for the stream beat tracker slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the counter-width helper and the default block-offset width.
package stream_beat_tracker_pkg;

    // Default width of a critical block offset (capture register width).
    localparam int unsigned SBT_BLOCK_OFFSET_W = 6;

    // Counter width for a given largest value: clog2(max+1), never below 1 bit.
    function automatic int unsigned sbt_cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_beat_tracker_if.sv
// Interface bundling the tracker's counter, flag and capture signals.
// Latency: n/a (wiring only).
// Backpressure: none; plain level signals, no handshake.
//
// slave  : tracker side (takes controls, drives cnt_o/streaming_o/cap_data_o)
// master : pump side (drives controls, observes tracker state)
interface stream_beat_tracker_if #(
    parameter int unsigned CW    = 3,
    parameter int unsigned CAP_W = 6
) ();
    logic             cnt_set_i;
    logic             cnt_en_i;
    logic [CW-1:0]    cnt_val_i;
    logic [CW-1:0]    cnt_o;
    logic             flag_set_i;
    logic             flag_clear_i;
    logic             streaming_o;
    logic             cap_en_i;
    logic [CAP_W-1:0] cap_data_i;
    logic [CAP_W-1:0] cap_data_o;

    modport slave (
        input  cnt_set_i, cnt_en_i, cnt_val_i,
        input  flag_set_i, flag_clear_i,
        input  cap_en_i, cap_data_i,
        output cnt_o, streaming_o, cap_data_o
    );

    modport master (
        output cnt_set_i, cnt_en_i, cnt_val_i,
        output flag_set_i, flag_clear_i,
        output cap_en_i, cap_data_i,
        input  cnt_o, streaming_o, cap_data_o
    );
endinterface

// File: rtl/stream_beat_tracker_counter.sv
// Loadable wrap-around beat counter (load beats increment).
// Latency: o_cnt reflects i_set/i_en one clock edge later.
// Backpressure: none; counter accepts a control every cycle.
//
// Ports: i_clk, i_rst_n (async active-low), i_set/i_val load, i_en increment,
// o_cnt registered count. Wraps from MAX_VAL to 0; any other value increments
// by one modulo 2^CW, so an out-of-range loaded value also rolls to 0.
module stream_beat_counter #(
    parameter int unsigned MAX_VAL   = 7,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned CW        = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_set,
    input  logic          i_en,
    input  logic [CW-1:0] i_val,
    output logic [CW-1:0] o_cnt
);
    localparam logic [CW-1:0] LP_MAX = CW'(MAX_VAL);
    localparam logic [CW-1:0] LP_RST = CW'(RESET_VAL);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_set) begin
            w_cnt_next = i_val;
        end else if (i_en) begin
            w_cnt_next = (r_cnt == LP_MAX) ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= LP_RST;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/stream_beat_tracker.sv
// Per-transaction bookkeeping for the stream pump: beat counter, streaming flag, critical-offset capture.
// Latency: cnt_o/streaming_o one edge after their controls; cap_data_o zero-latency through the bypass.
// Backpressure: none; every control is accepted every cycle.
//
// Ports: clk_i, reset_n_i (async active-low), bus (stream_beat_tracker_if.slave):
//   cnt_set_i/cnt_val_i/cnt_en_i -> cnt_o, flag_set_i/flag_clear_i -> streaming_o,
//   cap_en_i/cap_data_i -> cap_data_o.
// Optional macro STREAM_BEAT_TRACKER_CHECK_EN compiles simulation-only protocol checks.
module stream_beat_tracker
    import stream_beat_tracker_pkg::*;
#(
    parameter int unsigned max_val_p        = 7,
    parameter int unsigned reset_val_p      = 0,
    parameter int unsigned capture_width_p  = SBT_BLOCK_OFFSET_W,
    parameter bit          clear_over_set_p = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    stream_beat_tracker_if.slave  bus
);
    localparam int unsigned cw = sbt_cnt_width(max_val_p);

    logic                       r_streaming;
    logic                       w_streaming_next;
    logic [capture_width_p-1:0] r_cap;
    logic [cw-1:0]              w_cnt;

    stream_beat_counter #(
        .MAX_VAL   (max_val_p),
        .RESET_VAL (reset_val_p),
        .CW        (cw)
    ) u_counter (
        .i_clk   (clk_i),
        .i_rst_n (reset_n_i),
        .i_set   (bus.cnt_set_i),
        .i_en    (bus.cnt_en_i),
        .i_val   (bus.cnt_val_i),
        .o_cnt   (w_cnt)
    );

    assign bus.cnt_o = w_cnt;

    // Streaming flag; simultaneous set+clear resolved by clear_over_set_p.
    always_comb begin
        w_streaming_next = r_streaming;
        if (bus.flag_set_i && bus.flag_clear_i) begin
            w_streaming_next = ~clear_over_set_p;
        end else if (bus.flag_set_i) begin
            w_streaming_next = 1'b1;
        end else if (bus.flag_clear_i) begin
            w_streaming_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_streaming <= 1'b0;
        end else begin
            r_streaming <= w_streaming_next;
        end
    end

    assign bus.streaming_o = r_streaming;

    // Capture register: the pump holds cap_en_i high until streaming starts,
    // so the first beat's offset is visible the same cycle it arrives.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cap <= '0;
        end else if (bus.cap_en_i) begin
            r_cap <= bus.cap_data_i;
        end
    end

    assign bus.cap_data_o = bus.cap_en_i ? bus.cap_data_i : r_cap;

`ifdef STREAM_BEAT_TRACKER_CHECK_EN
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            if (bus.cnt_set_i === 1'b1 && int'(bus.cnt_val_i) > int'(max_val_p)) begin
                $error("stream_beat_tracker: load value %0d exceeds max %0d",
                       bus.cnt_val_i, max_val_p);
            end
            if (!clear_over_set_p && bus.flag_set_i === 1'b1 && bus.flag_clear_i === 1'b1) begin
                $error("stream_beat_tracker: flag set and clear together with set priority");
            end
            if ($isunknown({bus.cnt_set_i, bus.cnt_en_i, bus.flag_set_i,
                            bus.flag_clear_i, bus.cap_en_i})) begin
                $error("stream_beat_tracker: unknown value on a control input");
            end
        end
    end
`else
    // Checks not compiled; behaviour identical.
`endif

endmodule

// File: tb/tb_stream_beat_tracker.sv
module tb_stream_beat_tracker;

    typedef struct {
        logic       set;
        logic       en;
        logic [2:0] val;
        logic       fs;
        logic       fc;
        logic       ce;
        logic [5:0] cd;
    } stim_t;

    // Instance 0: max 7, reset 0, clear wins. 1: max 5, reset 3, set wins. 2: max 3, reset 0, clear wins.
    localparam int M_MAX [3] = '{7, 5, 3};
    localparam int M_RST [3] = '{0, 3, 0};
    localparam int M_COS [3] = '{1, 0, 1};

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    logic  chk_on = 1'b0;
    stim_t st [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_beat_tracker_if #(.CW(3), .CAP_W(6)) bus_a ();
    stream_beat_tracker_if #(.CW(3), .CAP_W(6)) bus_b ();
    stream_beat_tracker_if #(.CW(2), .CAP_W(6)) bus_c ();

    stream_beat_tracker #(.max_val_p(7), .reset_val_p(0), .capture_width_p(6), .clear_over_set_p(1'b1))
        u_dut_a (.clk_i(clk), .reset_n_i(rst_n), .bus(bus_a));
    stream_beat_tracker #(.max_val_p(5), .reset_val_p(3), .capture_width_p(6), .clear_over_set_p(1'b0))
        u_dut_b (.clk_i(clk), .reset_n_i(rst_n), .bus(bus_b));
    stream_beat_tracker #(.max_val_p(3), .reset_val_p(0), .capture_width_p(6), .clear_over_set_p(1'b1))
        u_dut_c (.clk_i(clk), .reset_n_i(rst_n), .bus(bus_c));

    assign bus_a.cnt_set_i = st[0].set;    assign bus_b.cnt_set_i = st[1].set;    assign bus_c.cnt_set_i = st[2].set;
    assign bus_a.cnt_en_i  = st[0].en;     assign bus_b.cnt_en_i  = st[1].en;     assign bus_c.cnt_en_i  = st[2].en;
    assign bus_a.cnt_val_i = st[0].val;    assign bus_b.cnt_val_i = st[1].val;    assign bus_c.cnt_val_i = st[2].val[1:0];
    assign bus_a.flag_set_i   = st[0].fs;  assign bus_b.flag_set_i   = st[1].fs;  assign bus_c.flag_set_i   = st[2].fs;
    assign bus_a.flag_clear_i = st[0].fc;  assign bus_b.flag_clear_i = st[1].fc;  assign bus_c.flag_clear_i = st[2].fc;
    assign bus_a.cap_en_i   = st[0].ce;    assign bus_b.cap_en_i   = st[1].ce;    assign bus_c.cap_en_i   = st[2].ce;
    assign bus_a.cap_data_i = st[0].cd;    assign bus_b.cap_data_i = st[1].cd;    assign bus_c.cap_data_i = st[2].cd;

    logic [2:0] o_cnt [3];
    logic       o_str [3];
    logic [5:0] o_cap [3];

    assign o_cnt[0] = bus_a.cnt_o;          assign o_str[0] = bus_a.streaming_o;  assign o_cap[0] = bus_a.cap_data_o;
    assign o_cnt[1] = bus_b.cnt_o;          assign o_str[1] = bus_b.streaming_o;  assign o_cap[1] = bus_b.cap_data_o;
    assign o_cnt[2] = {1'b0, bus_c.cnt_o};  assign o_str[2] = bus_c.streaming_o;  assign o_cap[2] = bus_c.cap_data_o;

    // Reference model: the rules stated as plain arithmetic on integers.
    int m_cnt  [3];
    int m_flag [3];
    int m_cap  [3];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_cnt[i]  <= M_RST[i];
                m_flag[i] <= 0;
                m_cap[i]  <= 0;
            end else begin
                if (st[i].set)     m_cnt[i] <= int'(st[i].val);
                else if (st[i].en) m_cnt[i] <= (m_cnt[i] + 1) % (M_MAX[i] + 1);
                if (st[i].fs && st[i].fc) m_flag[i] <= (M_COS[i] == 1) ? 0 : 1;
                else if (st[i].fs)        m_flag[i] <= 1;
                else if (st[i].fc)        m_flag[i] <= 0;
                if (st[i].ce) m_cap[i] <= int'(st[i].cd);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_cnt[%0d]", i), int'(o_cnt[i]), m_cnt[i]);
                chk($sformatf("model_str[%0d]", i), int'(o_str[i]), m_flag[i]);
                chk($sformatf("model_cap[%0d]", i), int'(o_cap[i]),
                    st[i].ce ? int'(st[i].cd) : m_cap[i]);
            end
        end
    end

    task automatic drv(input int i, input logic set, input logic en, input int val,
                       input logic fs, input logic fc, input logic ce, input int cd);
        st[i].set = set;
        st[i].en  = en;
        st[i].val = 3'(val);
        st[i].fs  = fs;
        st[i].fc  = fc;
        st[i].ce  = ce;
        st[i].cd  = 6'(cd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drv(i, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        chk_on = 1'b1;

        chk("rst_cnt_a", int'(o_cnt[0]), 0);
        chk("rst_str_a", int'(o_str[0]), 0);
        chk("rst_cap_a", int'(o_cap[0]), 0);
        chk("rst_cnt_b", int'(o_cnt[1]), 3);
        chk("rst_cnt_c", int'(o_cnt[2]), 0);

        // Wrap at 7 (a) and at 5 (b, non power of two).
        drv(0, 1, 0, 6, 0, 0, 0, 0);
        drv(1, 1, 0, 5, 0, 0, 0, 0);
        step(); chk("wrap_a_load", int'(o_cnt[0]), 6); chk("wrap_b_load", int'(o_cnt[1]), 5);
        drv(0, 0, 1, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0, 0, 0);
        step(); chk("wrap_a_7", int'(o_cnt[0]), 7); chk("wrap_b_0", int'(o_cnt[1]), 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        step(); chk("wrap_a_0", int'(o_cnt[0]), 0);
        step(); chk("wrap_a_1", int'(o_cnt[0]), 1);

        // Set beats enable.
        drv(0, 1, 0, 3, 0, 0, 0, 0);
        step(); chk("prio_load3", int'(o_cnt[0]), 3);
        drv(0, 1, 1, 2, 0, 0, 0, 0);
        step(); chk("prio_set_en", int'(o_cnt[0]), 2);
        drv(0, 1, 0, 1, 0, 0, 0, 0);
        step(); chk("prio_set_only", int'(o_cnt[0]), 1);

        // Flag priority: clear wins on a, set wins on b.
        drv(0, 0, 0, 0, 1, 1, 0, 0);
        drv(1, 0, 0, 0, 1, 1, 0, 0);
        step(); chk("flag_both_a", int'(o_str[0]), 0); chk("flag_both_b", int'(o_str[1]), 1);
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 1, 0, 0);
        step(); chk("flag_set_a", int'(o_str[0]), 1); chk("flag_clr_b", int'(o_str[1]), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        step(); chk("flag_hold_a", int'(o_str[0]), 1);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        step(); chk("flag_clr_a", int'(o_str[0]), 0);

        // Bypass then hold.
        drv(0, 0, 0, 0, 0, 0, 1, 'h13);
        #1 chk("byp_same_cycle", int'(o_cap[0]), 'h13);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 'h3F);
        #1 chk("byp_held", int'(o_cap[0]), 'h13);
        step(); chk("byp_held2", int'(o_cap[0]), 'h13);
        step(); chk("byp_held3", int'(o_cap[0]), 'h13);

        // Asynchronous reset mid-stream.
        drv(0, 1, 0, 5, 1, 0, 1, 'h2A);
        step(); chk("pre_rst_cnt", int'(o_cnt[0]), 5); chk("pre_rst_str", int'(o_str[0]), 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("pre_rst_cap", int'(o_cap[0]), 'h2A);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cnt_a", int'(o_cnt[0]), 0);
        chk("arst_str_a", int'(o_str[0]), 0);
        chk("arst_cap_a", int'(o_cap[0]), 0);
        chk("arst_cnt_b", int'(o_cnt[1]), 3);
        step(); step();
        rst_n = 1'b1;
        step(); chk("post_rst_cnt_a", int'(o_cnt[0]), 0);

        // Pump: 4-beat stream from critical offset 0x10 on the max-3 instance.
        drv(2, 1, 0, 2, 1, 0, 1, 'h10);
        #1 chk("pump_byp", int'(o_cap[2]), 'h10);
        step();
        chk("pump_cnt0", int'(o_cnt[2]), 2); chk("pump_str0", int'(o_str[2]), 1); chk("pump_cap0", int'(o_cap[2]), 'h10);
        drv(2, 0, 1, 0, 0, 0, 0, 'h05);
        step();
        chk("pump_cnt1", int'(o_cnt[2]), 3); chk("pump_str1", int'(o_str[2]), 1); chk("pump_cap1", int'(o_cap[2]), 'h10);
        step();
        chk("pump_cnt2", int'(o_cnt[2]), 0); chk("pump_str2", int'(o_str[2]), 1); chk("pump_cap2", int'(o_cap[2]), 'h10);
        drv(2, 0, 1, 0, 0, 1, 0, 'h05);
        step();
        chk("pump_cnt3", int'(o_cnt[2]), 1); chk("pump_str3", int'(o_str[2]), 0); chk("pump_cap3", int'(o_cap[2]), 'h10);
        drv(2, 0, 0, 0, 0, 0, 0, 'h05);
        step(); chk("pump_hold", int'(o_cnt[2]), 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
